// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// aes_pkg : shared AES types, arbiter state encoding and the S-box lookup
// Rev 1.0
// ============================================================================
package aes_pkg;

  localparam int AES_BLOCK_W = 128;

  typedef logic [7:0]             byte_t;
  typedef logic [AES_BLOCK_W-1:0] state_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  // Forward S-box, entry 0x00 in the most significant byte.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic byte_t sbox(input byte_t b);
    logic [10:0] idx;
    idx = {~b, 3'b000};
    return SBOX_TABLE[idx +: 8];
  endfunction

endpackage
`default_nettype wire

// File: rtl/subbyte_arbiter_if.sv
`default_nettype none
// ============================================================================
// subbyte_arbiter_if : request/response channels of the shared SubBytes unit
// Rev 1.0
// ============================================================================
interface subbyte_arbiter_if
  import aes_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
);
  logic [NUM_REQ-1:0]             req_valid;
  logic [NUM_REQ-1:0]             req_ready;
  logic [NUM_REQ*AES_BLOCK_W-1:0] req_data;
  logic                           resp_valid;
  logic                           resp_ready;
  state_t                         resp_data;
  logic [ID_W-1:0]                resp_id;
  logic                           busy;

  modport master (
    output req_valid, req_data, resp_ready,
    input  req_ready, resp_valid, resp_data, resp_id, busy
  );

  modport slave (
    input  req_valid, req_data, resp_ready,
    output req_ready, resp_valid, resp_data, resp_id, busy
  );
endinterface
`default_nettype wire

// File: rtl/subbyte.sv
`default_nettype none
// ============================================================================
// subbyte : combinational AES SubBytes over a 128-bit state word
// Rev 1.0
// ============================================================================
module subbyte
  import aes_pkg::*;
(
  input  state_t din,
  output state_t dout
);
  generate
    for (genvar i = 0; i < AES_BLOCK_W / 8; i++) begin : g_byte
      assign dout[8*i +: 8] = sbox(din[8*i +: 8]);
    end
  endgenerate
endmodule
`default_nettype wire

// File: rtl/subbyte_arbiter_rr.sv
`default_nettype none
// ============================================================================
// rr_arbiter : one-hot round-robin grant, search starts just above ptr
// Rev 1.0
// ============================================================================
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] gnt
);
  logic w_found;

  // Two ascending passes: indices above ptr first, then the wrap to 0..ptr.
  always_comb begin
    gnt     = '0;
    w_found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!w_found && req[i] && (i > int'(ptr))) begin
        gnt[i]  = 1'b1;
        w_found = 1'b1;
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!w_found && req[i] && (i <= int'(ptr))) begin
        gnt[i]  = 1'b1;
        w_found = 1'b1;
      end
    end
  end
endmodule
`default_nettype wire

// File: rtl/subbyte_arbiter.sv
`default_nettype none
// ============================================================================
// subbyte_arbiter : round-robin sharing of one SubBytes unit, one transaction
// in flight. Optional output register: SUBBYTE_ARB_OUT_REG_EN.   Rev 1.0
// ============================================================================
module subbyte_arbiter
  import aes_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk,
  input  logic               rst,
  subbyte_arbiter_if.slave   bus
);
`ifdef SUBBYTE_ARB_OUT_REG_EN
  localparam arb_state_e ST_AFTER_ACCEPT = SUB;
`else
  localparam arb_state_e ST_AFTER_ACCEPT = RESP;
`endif

  arb_state_e         r_state;
  arb_state_e         w_state_nxt;
  logic [NUM_REQ-1:0] w_gnt;
  logic               w_open;
  logic               w_accept;
  logic [ID_W-1:0]    w_gnt_idx;
  state_t             w_sel_data;
  state_t             r_in;
  state_t             w_sub;
  logic [ID_W-1:0]    r_id;
  logic [ID_W-1:0]    r_ptr;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_rr (
    .req (bus.req_valid),
    .ptr (r_ptr),
    .gnt (w_gnt)
  );

  assign w_open        = (r_state == IDLE) || ((r_state == RESP) && bus.resp_ready);
  assign bus.req_ready = w_gnt & {NUM_REQ{w_open}};
  assign w_accept      = |(bus.req_valid & bus.req_ready);

  always_comb begin
    w_gnt_idx  = '0;
    w_sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_gnt[i]) begin
        w_gnt_idx  = ID_W'(i);
        w_sel_data = bus.req_data[AES_BLOCK_W*i +: AES_BLOCK_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (w_accept) w_state_nxt = ST_AFTER_ACCEPT;
      RESP: if (bus.resp_ready) w_state_nxt = w_accept ? ST_AFTER_ACCEPT : IDLE;
`ifdef SUBBYTE_ARB_OUT_REG_EN
      SUB:  w_state_nxt = RESP;
`endif
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_in  <= '0;
      r_id  <= '0;
      r_ptr <= ID_W'(NUM_REQ - 1);
    end else if (w_accept) begin
      r_in  <= w_sel_data;
      r_id  <= w_gnt_idx;
      r_ptr <= w_gnt_idx;
    end
  end

  subbyte u_sub (
    .din  (r_in),
    .dout (w_sub)
  );

`ifdef SUBBYTE_ARB_OUT_REG_EN
  state_t r_out;

  always_ff @(posedge clk) begin
    if (rst)                 r_out <= '0;
    else if (r_state == SUB) r_out <= w_sub;
  end

  assign bus.resp_data = r_out;
`else
  // Zero outside RESP so the idle bus never shows SubBytes of a stale word.
  assign bus.resp_data = (r_state == RESP) ? w_sub : '0;
`endif

  assign bus.resp_valid = (r_state == RESP);
  assign bus.resp_id    = r_id;
  assign bus.busy       = (r_state != IDLE);
endmodule
`default_nettype wire

// File: tb/tb_subbyte_arbiter.sv
`default_nettype none
// ============================================================================
// tb_subbyte_arbiter : directed bench for subbyte_arbiter (default build)
// Rev 1.0
// ============================================================================
module tb_subbyte_arbiter;
  import aes_pkg::*;

  localparam int NUM_REQ = 2;

  logic clk = 1'b0;
  logic rst;
  int   n_total = 0;
  int   n_pass  = 0;

  always #5 clk = ~clk;

  subbyte_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

  subbyte_arbiter #(.NUM_REQ(NUM_REQ)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] v, input state_t d0, input state_t d1);
    bus.req_valid = v;
    bus.req_data  = {d1, d0};
    #1;
  endtask

  function automatic state_t rep(input byte_t b);
    return {16{b}};
  endfunction

  initial begin
    byte_t burst_in  [4];
    byte_t burst_exp [4];
    burst_in  = '{8'h01, 8'h02, 8'h03, 8'h04};
    burst_exp = '{8'h7c, 8'h77, 8'h7b, 8'hf2};

    rst            = 1'b1;
    bus.req_valid  = '0;
    bus.req_data   = '0;
    bus.resp_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("rst_resp_valid", 128'(bus.resp_valid), 128'd0);
    check("rst_resp_data",  bus.resp_data,        128'd0);
    check("rst_resp_id",    128'(bus.resp_id),    128'd0);
    check("rst_busy",       128'(bus.busy),       128'd0);
    check("rst_req_ready",  128'(bus.req_ready),  128'd0);

    // All-zero word from requester 0, one-cycle latency
    drive(2'b01, '0, '0);
    check("zero_req_ready", 128'(bus.req_ready), 128'd1);
    tick();
    drive(2'b00, '0, '0);
    check("zero_resp_valid", 128'(bus.resp_valid), 128'd1);
    check("zero_resp_data",  bus.resp_data, 128'h63636363_63636363_63636363_63636363);
    check("zero_resp_id",    128'(bus.resp_id), 128'd0);
    check("zero_busy",       128'(bus.busy), 128'd1);
    tick();
    check("zero_done_valid", 128'(bus.resp_valid), 128'd0);
    check("zero_done_busy",  128'(bus.busy), 128'd0);

    // Known vector from requester 1
    drive(2'b10, '0, 128'h00112233_44556677_8899aabb_ccddeeff);
    check("kv_req_ready", 128'(bus.req_ready), 128'd2);
    tick();
    drive(2'b00, '0, '0);
    check("kv_resp_data", bus.resp_data, 128'h638293c3_1bfc33f5_c4eeacea_4bc12816);
    check("kv_resp_id",   128'(bus.resp_id), 128'd1);
    tick();

    // Round robin with both requesters continuously valid
    drive(2'b11, rep(8'h10), rep(8'h20));
    check("rr_first_gnt", 128'(bus.req_ready), 128'd1);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("rr_resp_valid", 128'(bus.resp_valid), 128'd1);
      check("rr_resp_id",    128'(bus.resp_id), 128'(k % 2));
      check("rr_resp_data",  bus.resp_data, (k % 2 == 0) ? rep(8'hca) : rep(8'hb7));
      check("rr_next_gnt",   128'(bus.req_ready), (k % 2 == 0) ? 128'd2 : 128'd1);
    end
    drive(2'b00, '0, '0);
    tick();
    check("rr_idle", 128'(bus.resp_valid), 128'd0);

    // Backpressure: response and ids hold, nothing accepted
    bus.resp_ready = 1'b0;
    drive(2'b11, rep(8'h30), rep(8'h40));
    check("bp_first_gnt", 128'(bus.req_ready), 128'd1);
    tick();
    drive(2'b11, rep(8'ha5), rep(8'h40));
    for (int c = 0; c < 5; c++) begin
      check("bp_resp_valid", 128'(bus.resp_valid), 128'd1);
      check("bp_resp_data",  bus.resp_data, rep(8'h04));
      check("bp_resp_id",    128'(bus.resp_id), 128'd0);
      check("bp_req_ready",  128'(bus.req_ready), 128'd0);
      tick();
    end
    bus.resp_ready = 1'b1;
    #1;
    check("bp_release_gnt", 128'(bus.req_ready), 128'd2);
    tick();
    check("bp_b2b_valid", 128'(bus.resp_valid), 128'd1);
    check("bp_b2b_data",  bus.resp_data, rep(8'h09));
    check("bp_b2b_id",    128'(bus.resp_id), 128'd1);
    drive(2'b00, '0, '0);
    tick();
    check("bp_idle", 128'(bus.resp_valid), 128'd0);

    // Reset while a response is pending; pointer must return to requester 0
    bus.resp_ready = 1'b0;
    drive(2'b01, rep(8'h01), '0);
    tick();
    drive(2'b00, '0, '0);
    check("mid_pending_valid", 128'(bus.resp_valid), 128'd1);
    rst = 1'b1;
    tick();
    check("mid_rst_valid", 128'(bus.resp_valid), 128'd0);
    check("mid_rst_busy",  128'(bus.busy), 128'd0);
    check("mid_rst_data",  bus.resp_data, 128'd0);
    rst = 1'b0;
    drive(2'b11, rep(8'h11), rep(8'h22));
    check("mid_post_rst_gnt", 128'(bus.req_ready), 128'd1);
    drive(2'b00, '0, '0);
    bus.resp_ready = 1'b1;
    tick();

    // Single requester burst, one word per cycle
    for (int k = 0; k < 4; k++) begin
      drive(2'b10, rep(8'hee), rep(burst_in[k]));
      check("burst_req_ready", 128'(bus.req_ready), 128'd2);
      tick();
      check("burst_resp_valid", 128'(bus.resp_valid), 128'd1);
      check("burst_resp_id",    128'(bus.resp_id), 128'd1);
      check("burst_resp_data",  bus.resp_data, rep(burst_exp[k]));
    end
    drive(2'b00, '0, '0);
    tick();
    check("burst_idle_valid", 128'(bus.resp_valid), 128'd0);
    check("burst_idle_busy",  128'(bus.busy), 128'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/subbyte_arbiter.md
Name: subbyte_arbiter

Overview:
- Shares a single 128-bit `subbyte` (AES SubBytes) instance between NUM_REQ requesters, e.g. the round datapath and the key-expansion unit.
- Round-robin arbitration with one outstanding transaction at a time.
- Valid/ready request channels; one response channel tagged with the requester id.
- Sits between the AES round controller/key schedule and the S-box datapath.

Parameters:
- NUM_REQ, 2, number of requesters (2..8)
- ID_W, $clog2(NUM_REQ) (min 1), width of resp_id

Ports:
- clk  in  1  clock, all logic rising-edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  per-requester accept, at most one bit high
- req_data  in  NUM_REQ*128  flattened state words; requester i uses bits [128*i+127:128*i]
- resp_valid  out  1  substituted result available
- resp_ready  in  1  response consumer ready
- resp_data  out  128  SubBytes(captured word), byte-wise
- resp_id  out  ID_W  index of requester owning resp_data
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset values: state=IDLE, resp_valid=0, resp_data=0, resp_id=0, busy=0, rr_ptr=NUM_REQ-1 (requester 0 has top priority first).
- Grant: combinational one-hot over req_valid. Search starts at rr_ptr+1 mod NUM_REQ and wraps; the first valid index wins.
- Accept window: open = (state==IDLE) | (state==RESP & resp_ready).
  - req_ready = grant & {NUM_REQ{open}}.
  - req_ready never depends on the unselected requesters' data.
- Accept (req_valid[i] & req_ready[i]):
  - in_reg <= req_data slice i; id_reg <= i; rr_ptr <= i.
- States: IDLE, SUB (only with the macro), RESP.
  - IDLE: accept -> RESP (or SUB with the macro); otherwise stay.
  - RESP: resp_valid=1.
    - resp_ready & accept -> RESP/SUB with the new word (back-to-back).
    - resp_ready & no accept -> IDLE.
    - !resp_ready -> hold RESP; resp_data and resp_id stable.
  - SUB: one cycle, unconditionally -> RESP.
- Datapath:
  - resp_data = subbyte(in_reg), combinational from in_reg.
  - Latency: accept at cycle N -> resp_valid at N+1.
  - Throughput: 1 word/cycle while resp_ready is held high.
- resp_id = id_reg.
- Requester fairness: a continuously-valid requester waits at most NUM_REQ-1 grants.
- Request data held by a requester is not required to be stable after acceptance.
- Simultaneous events:
  - Accept and response completion in the same cycle are legal; the new capture wins.
  - A single requester asserting alone is granted every opportunity.
- Reset mid-operation: the pending response is dropped. resp_valid=0 and state=IDLE on the cycle after rst is sampled high; no partial response is ever emitted.
- Dropping req_valid before acceptance is permitted; the grant simply moves.

Optional Feature:
- Macro SUBBYTE_ARB_OUT_REG_EN.
- Defined:
  - Adds the SUB state and a 128-bit out_reg <= subbyte(in_reg) captured in SUB.
  - resp_data = out_reg; out_reg resets to 0.
  - Latency becomes 2 cycles (accept N -> resp_valid N+2).
  - Accept window is IDLE or (RESP & resp_ready), as before, so peak throughput is 1 word per 2 cycles.
- Undefined: no SUB state, no out_reg, latency 1 cycle as above.

Decomposition:
- Shared package aes_pkg holds:
  - typedef state_t (128-bit word) and byte_t.
  - localparam AES_BLOCK_W=128.
  - enum arb_state_e {IDLE, SUB, RESP}.
- Sub-module: rr_arbiter (NUM_REQ-wide, one-hot grant from req vector and pointer), reusable elsewhere.
- `subbyte` is instantiated unchanged.

Test Plan:
- All-zero word: req0 sends 0 -> resp_data=0x63636363_63636363_63636363_63636363, resp_id=0, resp_valid at N+1 (N+2 with macro).
- Known vector: req1 sends 0x00112233_44556677_8899aabb_ccddeeff -> resp_data=0x638293c3_1bfc33f5_c4eeacea_4bc12816, resp_id=1.
- Round robin: both requesters valid continuously, resp_ready=1 -> grants 0,1,0,1, one per cycle, resp_id alternating; no missing words.
- Backpressure: hold resp_ready=0 for 5 cycles -> resp_valid, resp_data and resp_id stable; req_ready=0 throughout; release -> completion and the next accept in the same cycle.
- Reset mid-op: assert rst while in RESP -> next cycle resp_valid=0, busy=0, and the first grant after reset goes to requester 0.
- Single requester burst: req1 only, 4 words 0x01.., 0x02.., 0x03.., 0x04.. (all bytes equal) -> responses 0x7c.., 0x77.., 0x7b.., 0xf2.. in order, all resp_id=1.
